// File: rtl/ptw_req_arbiter.sv
// rtl/ptw_req_arbiter.sv - round-robin arbiter sharing one page-table walker among NUM_REQ requesters
// Optional walk watchdog and timeout_flag port enabled by defining PTW_ARB_TIMEOUT_EN.
module ptw_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int VA_W        = 48,
    parameter int PA_W        = 48,
    parameter int TIMEOUT_CYC = 1024,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*VA_W-1:0] req_vaddr,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [PA_W-1:0]         rsp_paddr,
    output logic                    rsp_error,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    walk_start,
    output logic [VA_W-1:0]         walk_vaddr,
`ifdef PTW_ARB_TIMEOUT_EN
    output logic                    timeout_flag,
`endif
    input  logic                    walk_done,
    input  logic                    walk_error,
    input  logic [PA_W-1:0]         walk_paddr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic              first_wait;
    logic [ID_W-1:0]   sel;
    logic              any_req;
    logic [VA_W-1:0]   sel_vaddr;
`ifdef PTW_ARB_TIMEOUT_EN
    logic [31:0]       wd_cnt;
`endif

    // First requesting port at or above rr_ptr, wrapping around.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                any_req = 1'b1;
                sel     = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign sel_vaddr = req_vaddr[int'(sel)*VA_W +: VA_W];
    assign req_ready = (ARESETN && state == IDLE && any_req) ? (NUM_REQ'(1) << sel) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            first_wait   <= 1'b0;
            grant_id     <= '0;
            walk_start   <= 1'b0;
            walk_vaddr   <= '0;
            rsp_valid    <= '0;
            rsp_paddr    <= '0;
            rsp_error    <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            walk_start <= 1'b0;
            rsp_valid  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        walk_vaddr <= sel_vaddr;
                        grant_id   <= sel;
                        rr_ptr     <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                        walk_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    first_wait <= 1'b1;
`ifdef PTW_ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    // done is still the previous walk's level in the first WAIT cycle
                    first_wait <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
                    wd_cnt     <= wd_cnt + 32'd1;
`endif
                    if (!first_wait && walk_done) begin
                        rsp_paddr <= walk_paddr;
                        rsp_error <= walk_error;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
                    end
`ifdef PTW_ARB_TIMEOUT_EN
                    else if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        rsp_paddr    <= '0;
                        rsp_error    <= 1'b1;
                        timeout_flag <= 1'b1;
                        rsp_valid    <= NUM_REQ'(1) << grant_id;
                        state        <= RESP;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
